sram_arbiter: RTL

- Single-clock two-port arbiter for the 16x128 buffer SRAM.
- Port A is the host-bus side; port B is the SD data-path side.
- Grants at most one access (read or write) per cycle using round-robin with a bounded burst hold.
- Drives the SRAM write/read strobes, pointers and data, and returns read data with a per-port valid one cycle after the read grant.
- The top level ties SRAM clk_wr and clk_rd to clk.

---
 rtl/sram_arb_pkg.sv | 27 ++
 rtl/rr_burst_picker.sv | 47 ++++
 rtl/sram_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared encodings and defaults for the two-port buffer SRAM arbiter.
package sram_arb_pkg;

  localparam int ADDR_W_DEF    = 7;
  localparam int DATA_W_DEF    = 16;
  localparam int MAX_BURST_DEF = 4;
  localparam int CNT_W         = 4;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } owner_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Burst counter step: restart at 1 on an owner change, saturate otherwise.
  function automatic logic [CNT_W-1:0] cnt_next(input logic same_owner,
                                                 input logic [CNT_W-1:0] cnt);
    if (!same_owner) return CNT_W'(1);
    return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/rr_burst_picker.sv
// Round-robin grant with bounded burst hold; purely combinational.
module rr_burst_picker
  import sram_arb_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic             req_a,
  input  logic             req_b,
  input  owner_e           owner,
  input  logic [CNT_W-1:0] cnt,
  input  logic             last,
  output logic             gnt_a,
  output logic             gnt_b
);

  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

  logic burst_open;
  assign burst_open = (cnt < BURST_LIM);

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (req_a && !req_b) begin
      gnt_a = 1'b1;
    end else if (req_b && !req_a) begin
      gnt_b = 1'b1;
    end else if (req_a && req_b) begin
      // Under contention the owner keeps the port until its burst is used up.
      case (owner)
        OWN_A: begin
          gnt_a = burst_open;
          gnt_b = !burst_open;
        end
        OWN_B: begin
          gnt_b = burst_open;
          gnt_a = !burst_open;
        end
        default: begin
          gnt_a = (last == PORT_B);
          gnt_b = (last == PORT_A);
        end
      endcase
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port (host A / SD datapath B) arbiter for the 16x128 buffer SRAM.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              sram_wr_en,
  output logic [ADDR_W-1:0] sram_wr_ptr,
  output logic [DATA_W-1:0] sram_din,
  output logic              sram_rd_en,
  output logic [ADDR_W-1:0] sram_rd_ptr,
  input  logic [DATA_W-1:0] sram_dout
);

  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             a_rvalid_q, a_rvalid_d;
  logic             b_rvalid_q, b_rvalid_d;

  rr_burst_picker #(.MAX_BURST(MAX_BURST)) u_picker (
    .req_a (a_req),
    .req_b (b_req),
    .owner (owner_q),
    .cnt   (cnt_q),
    .last  (last_q),
    .gnt_a (a_gnt),
    .gnt_b (b_gnt)
  );

  always_comb begin
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    a_rvalid_d = a_gnt && !a_we;
    b_rvalid_d = b_gnt && !b_we;
    if (a_gnt) begin
      owner_d = OWN_A;
      cnt_d   = cnt_next(owner_q == OWN_A, cnt_q);
      last_d  = PORT_A;
    end else if (b_gnt) begin
      owner_d = OWN_B;
      cnt_d   = cnt_next(owner_q == OWN_B, cnt_q);
      last_d  = PORT_B;
    end else begin
      // last is kept so the next tie still alternates after an idle gap.
      owner_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= PORT_B;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

  // SRAM strobes follow the single granted port; idle buses are parked at 0.
  always_comb begin
    sram_wr_en  = 1'b0;
    sram_wr_ptr = '0;
    sram_din    = '0;
    sram_rd_en  = 1'b0;
    sram_rd_ptr = '0;
    if (a_gnt) begin
      if (a_we) begin
        sram_wr_en  = 1'b1;
        sram_wr_ptr = a_addr;
        sram_din    = a_wdata;
      end else begin
        sram_rd_en  = 1'b1;
        sram_rd_ptr = a_addr;
      end
    end else if (b_gnt) begin
      if (b_we) begin
        sram_wr_en  = 1'b1;
        sram_wr_ptr = b_addr;
        sram_din    = b_wdata;
      end else begin
        sram_rd_en  = 1'b1;
        sram_rd_ptr = b_addr;
      end
    end
  end

  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign rdata    = sram_dout;

endmodule
